// File: rtl/rename_rrat_if.sv
// Bus between the front end and the rename table block: rename lanes, commit
// lanes and recovery controls.
interface rename_rrat_if #(
  parameter int RWD   = 2,
  parameter int CWD   = 2,
  parameter int ANUM  = 32,
  parameter int PRNUM = 64,
  parameter int BRSZ  = 4
);
  localparam int AW = $clog2(ANUM);
  localparam int PW = $clog2(PRNUM);
  localparam int BW = (BRSZ > 1) ? $clog2(BRSZ) : 1;

  logic [RWD-1:0]         in_valid;
  logic [RWD-1:0][AW-1:0] in_rd;
  logic [RWD-1:0][AW-1:0] in_rs1;
  logic [RWD-1:0][AW-1:0] in_rs2;
  logic [RWD-1:0]         in_br;
  logic [RWD-1:0][BW-1:0] in_brid;
  logic [RWD-1:0]         ready;
  logic [RWD-1:0]         out_valid;
  logic [RWD-1:0][PW-1:0] out_prs1;
  logic [RWD-1:0][PW-1:0] out_prs2;
  logic [RWD-1:0][PW-1:0] out_prd;
  logic [RWD-1:0][PW-1:0] out_old_prd;
  logic [CWD-1:0]         com_valid;
  logic [CWD-1:0][AW-1:0] com_rd;
  logic [CWD-1:0][PW-1:0] com_prd;
  logic [CWD-1:0][PW-1:0] com_old_prd;
  logic                   kill;
  logic [BW-1:0]          kill_brid;
  logic                   flush;
  logic                   busy;
  logic [PW:0]            free_cnt;

  modport master (
    output in_valid, in_rd, in_rs1, in_rs2, in_br, in_brid,
    output com_valid, com_rd, com_prd, com_old_prd,
    output kill, kill_brid, flush,
    input  ready, out_valid, out_prs1, out_prs2, out_prd, out_old_prd,
    input  busy, free_cnt
  );

  modport slave (
    input  in_valid, in_rd, in_rs1, in_rs2, in_br, in_brid,
    input  com_valid, com_rd, com_prd, com_old_prd,
    input  kill, kill_brid, flush,
    output ready, out_valid, out_prs1, out_prs2, out_prd, out_old_prd,
    output busy, free_cnt
  );
endinterface

// File: rtl/rename_rrat.sv
// Register rename table with retirement RAT, free list, branch snapshots and
// a multi-cycle free-list rebuild after a pipeline flush.
module rename_rrat #(
  parameter int RWD   = 2,
  parameter int CWD   = 2,
  parameter int ANUM  = 32,
  parameter int PRNUM = 64,
  parameter int BRSZ  = 4,
  parameter int RBLD  = 8
) (
  input logic          clk,
  input logic          rst,
  rename_rrat_if.slave bus
);
  localparam int AW   = $clog2(ANUM);
  localparam int PW   = $clog2(PRNUM);
  localparam int RCYC = ANUM / RBLD;
  localparam int RCW  = (RCYC > 1) ? $clog2(RCYC) : 1;

  typedef enum logic {RUN = 1'b0, RECOVER = 1'b1} state_t;
  typedef logic [PW-1:0]            preg_t;
  typedef logic [ANUM-1:0][PW-1:0]  map_t;
  typedef logic [PRNUM-1:0]         free_t;

  // Everything above the architectural range starts free; register 0 never is.
  localparam free_t FREE_RST  = ~free_t'(0) << ANUM;
  localparam free_t FREE_ALL  = ~free_t'(1);

  function automatic map_t identity_map();
    map_t m;
    for (int a = 0; a < ANUM; a++) m[a] = PW'(a);
    return m;
  endfunction

  state_t          state_q, state_d;
  logic [RCW-1:0]  rb_q, rb_d;
  map_t            map_q, map_d, rrat_q, rrat_d;
  free_t           free_q, free_d;
  logic [PW:0]     cnt_q, cnt_d;
  logic [BRSZ-1:0] snap_vld_q, snap_vld_d;
  map_t            snap_map_q  [BRSZ];
  map_t            snap_map_d  [BRSZ];
  free_t           snap_free_q [BRSZ];
  free_t           snap_free_d [BRSZ];

  map_t            ren_map;
  free_t           ren_free;
  map_t            lane_map  [RWD];
  free_t           lane_free [RWD];
  logic [RWD-1:0]  fire;
  map_t            com_rrat;
  free_t           com_free;

  // Rename lanes in order, each seeing the mappings and allocations of lower lanes.
  always_comb begin
    logic  chain;
    logic  found;
    preg_t pick;
    // NOTE: combinational blocks use blocking assignments and give every output a
    // default first, so lane i reads lane i-1's result and no latch is inferred.
    ren_map         = map_q;
    ren_free        = free_q;
    fire            = '0;
    bus.ready       = '0;
    bus.out_prs1    = '0;
    bus.out_prs2    = '0;
    bus.out_prd     = '0;
    bus.out_old_prd = '0;
    chain = rst && (state_q == RUN) && !bus.kill && !bus.flush;
    for (int i = 0; i < RWD; i++) begin
      found = 1'b0;
      pick  = '0;
      for (int p = PRNUM - 1; p >= 0; p--) begin
        if (ren_free[p]) begin
          found = 1'b1;
          pick  = preg_t'(p);
        end
      end
      bus.ready[i]    = chain && found;
      fire[i]         = bus.ready[i] && bus.in_valid[i];
      bus.out_prs1[i] = ren_map[bus.in_rs1[i]];
      bus.out_prs2[i] = ren_map[bus.in_rs2[i]];
      if (bus.in_rd[i] != '0) begin
        bus.out_prd[i]     = pick;
        bus.out_old_prd[i] = ren_map[bus.in_rd[i]];
        if (fire[i]) begin
          ren_map[bus.in_rd[i]] = pick;
          ren_free[pick]        = 1'b0;
        end
      end
      lane_map[i]  = ren_map;
      lane_free[i] = ren_free;
      chain        = fire[i];
    end
  end

  assign bus.out_valid = fire;
  assign bus.busy      = rst && (state_q == RECOVER);
  assign bus.free_cnt  = cnt_q;

  // Commit lanes: later lanes overwrite earlier ones; freed old mappings collected.
  always_comb begin
    com_rrat = rrat_q;
    com_free = '0;
    for (int c = 0; c < CWD; c++) begin
      if (bus.com_valid[c]) begin
        if (bus.com_rd[c] != '0)      com_rrat[bus.com_rd[c]] = bus.com_prd[c];
        if (bus.com_old_prd[c] != '0) com_free[bus.com_old_prd[c]] = 1'b1;
      end
    end
  end

  // Next-state logic: RUN handles rename/commit/kill/flush, RECOVER rebuilds the free list.
  always_comb begin
    logic [AW-1:0] ai;
    state_d     = state_q;
    rb_d        = rb_q;
    map_d       = map_q;
    rrat_d      = rrat_q;
    free_d      = free_q;
    snap_vld_d  = snap_vld_q;
    snap_map_d  = snap_map_q;
    snap_free_d = snap_free_q;
    case (state_q)
      RUN: begin
        rrat_d = com_rrat;
        if (bus.flush) begin
          map_d      = com_rrat;
          free_d     = FREE_ALL;
          snap_vld_d = '0;
          rb_d       = '0;
          state_d    = RECOVER;
        end else begin
          for (int b = 0; b < BRSZ; b++) snap_free_d[b] = snap_free_q[b] | com_free;
          if (bus.kill) begin
            if (snap_vld_q[bus.kill_brid]) begin
              map_d  = snap_map_q[bus.kill_brid];
              free_d = snap_free_q[bus.kill_brid] | com_free;
            end else begin
              free_d = free_q | com_free;
            end
          end else begin
            map_d  = ren_map;
            free_d = ren_free | com_free;
            for (int i = 0; i < RWD; i++) begin
              if (fire[i] && bus.in_br[i]) begin
                snap_map_d[bus.in_brid[i]]  = lane_map[i];
                snap_free_d[bus.in_brid[i]] = lane_free[i] | com_free;
                snap_vld_d[bus.in_brid[i]]  = 1'b1;
              end
            end
          end
        end
      end
      RECOVER: begin
        if (bus.flush) begin
          rb_d = '0;
        end else begin
          for (int k = 0; k < RBLD; k++) begin
            ai = AW'(int'(rb_q) * RBLD + k);
            free_d[rrat_q[ai]] = 1'b0;
          end
          rb_d = rb_q + 1'b1;
          if (rb_q == RCW'(RCYC - 1)) begin
            rb_d    = '0;
            state_d = RUN;
          end
        end
      end
      default: state_d = RUN;
    endcase
    cnt_d = '0;
    for (int p = 0; p < PRNUM; p++) cnt_d = cnt_d + {{PW{1'b0}}, free_d[p]};
  end

  // Control state, tables and free list; reset wins over everything else.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= RUN;
      rb_q       <= '0;
      map_q      <= identity_map();
      rrat_q     <= identity_map();
      free_q     <= FREE_RST;
      cnt_q      <= (PW + 1)'(PRNUM - ANUM);
      snap_vld_q <= '0;
    end else begin
      state_q    <= state_d;
      rb_q       <= rb_d;
      map_q      <= map_d;
      rrat_q     <= rrat_d;
      free_q     <= free_d;
      cnt_q      <= cnt_d;
      snap_vld_q <= snap_vld_d;
    end
  end

  // Snapshot storage.
  // NOTE: snapshot contents are not reset; the valid bits guard every read.
  always_ff @(posedge clk) begin
    snap_map_q  <= snap_map_d;
    snap_free_q <= snap_free_d;
  end
endmodule

// File: tb/tb_rename_rrat.sv
// Directed bench for rename_rrat: expectations queued as stimulus is driven,
// popped and compared as the DUT responds.
module tb_rename_rrat;
  localparam int AW = 5;
  localparam int PW = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rename_rrat_if bus ();
  rename_rrat dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { string tag; int exp; } exp_t;
  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic want(input string tag, input int exp);
    sb.push_back('{tag, exp});
  endtask

  task automatic check(input int obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty got=%0d", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.exp) else begin
      bad++;
      $error("FAIL %s got=%0d want=%0d", e.tag, obs, e.exp);
    end
  endtask

  task automatic idle();
    bus.in_valid = '0; bus.in_rd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0;
    bus.in_br = '0; bus.in_brid = '0;
    bus.com_valid = '0; bus.com_rd = '0; bus.com_prd = '0; bus.com_old_prd = '0;
    bus.kill = 1'b0; bus.kill_brid = '0; bus.flush = 1'b0;
  endtask

  task automatic lane(input int i, input int rd, input int rs1, input int rs2,
                      input bit br = 1'b0, input int brid = 0);
    bus.in_valid[i] = 1'b1;
    bus.in_rd[i]    = AW'(rd);
    bus.in_rs1[i]   = AW'(rs1);
    bus.in_rs2[i]   = AW'(rs2);
    bus.in_br[i]    = br;
    bus.in_brid[i]  = 2'(brid);
  endtask

  task automatic commit(input int c, input int rd, input int prd, input int old);
    bus.com_valid[c]   = 1'b1;
    bus.com_rd[c]      = AW'(rd);
    bus.com_prd[c]     = PW'(prd);
    bus.com_old_prd[c] = PW'(old);
  endtask

  // Advance one clock; inputs change and outputs are sampled around the negedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    idle();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle();
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    idle();
    @(negedge clk);
    // Reset: renames refused, registered state at reset values.
    lane(0, 1, 0, 0); lane(1, 2, 0, 0);
    #1;
    want("rst_ready", 0);     check(int'(bus.ready));
    want("rst_out_valid", 0); check(int'(bus.out_valid));
    tick();
    want("rst_busy", 0);      check(int'(bus.busy));
    want("rst_free_cnt", 32); check(int'(bus.free_cnt));
    rst = 1'b1;

    // Two lanes write rd=5; lane1 reads it back through the bypass.
    lane(0, 5, 0, 0); lane(1, 5, 5, 0);
    #1;
    want("b_ready", 3);     check(int'(bus.ready));
    want("b_valid", 3);     check(int'(bus.out_valid));
    want("b_prd0", 32);     check(int'(bus.out_prd[0]));
    want("b_prd1", 33);     check(int'(bus.out_prd[1]));
    want("b_prs1_1", 32);   check(int'(bus.out_prs1[1]));
    want("b_old0", 5);      check(int'(bus.out_old_prd[0]));
    want("b_old1", 32);     check(int'(bus.out_old_prd[1]));
    tick();
    want("b_free_cnt", 30); check(int'(bus.free_cnt));

    // rd=0 allocates nothing.
    do_reset();
    lane(0, 0, 0, 0); lane(1, 7, 0, 0);
    #1;
    want("z_prd0", 0);      check(int'(bus.out_prd[0]));
    want("z_old0", 0);      check(int'(bus.out_old_prd[0]));
    want("z_prd1", 32);     check(int'(bus.out_prd[1]));
    tick();
    want("z_free_cnt", 31); check(int'(bus.free_cnt));

    // Snapshot on brid 1, rename past it, kill back.
    do_reset();
    lane(0, 3, 0, 0, 1'b1, 1);
    #1;
    want("k_prd_a", 32);    check(int'(bus.out_prd[0]));
    tick();
    lane(0, 3, 0, 0);
    #1;
    want("k_prd_b", 33);    check(int'(bus.out_prd[0]));
    tick();
    bus.kill = 1'b1; bus.kill_brid = 2'd1;
    lane(0, 4, 0, 0);
    #1;
    want("k_ready_kill", 0); check(int'(bus.ready));
    tick();
    want("k_free_cnt", 31); check(int'(bus.free_cnt));
    lane(0, 9, 3, 0);
    #1;
    want("k_prs1", 32);     check(int'(bus.out_prs1[0]));
    want("k_prd_c", 33);    check(int'(bus.out_prd[0]));
    tick();

    // Exhaust the free list, then a commit frees register 4.
    do_reset();
    for (int n = 0; n < 16; n++) begin
      lane(0, 1, 0, 0); lane(1, 1, 0, 0);
      tick();
    end
    want("e_free_cnt", 0);  check(int'(bus.free_cnt));
    lane(0, 1, 0, 0); lane(1, 1, 0, 0);
    commit(0, 1, 33, 4);
    #1;
    want("e_ready_empty", 0); check(int'(bus.ready));
    tick();
    lane(0, 1, 0, 0); lane(1, 1, 0, 0);
    #1;
    want("e_ready_one", 1); check(int'(bus.ready));
    want("e_prd", 4);       check(int'(bus.out_prd[0]));
    tick();

    // Commit, then flush with same-register commits; rebuild takes 4 cycles.
    do_reset();
    commit(0, 2, 40, 0);
    tick();
    bus.flush = 1'b1;
    commit(0, 8, 50, 0); commit(1, 8, 51, 0);
    tick();
    for (int n = 0; n < 4; n++) begin
      lane(0, 5, 0, 0); lane(1, 6, 0, 0);
      #1;
      want("f_busy", 1);    check(int'(bus.busy));
      want("f_ready", 0);   check(int'(bus.ready));
      tick();
    end
    want("f_busy_done", 0); check(int'(bus.busy));
    want("f_free_cnt", 32); check(int'(bus.free_cnt));
    lane(0, 5, 2, 8); lane(1, 6, 5, 0);
    #1;
    want("f_prs1", 40);     check(int'(bus.out_prs1[0]));
    want("f_prs2", 51);     check(int'(bus.out_prs2[0]));
    want("f_prd0", 2);      check(int'(bus.out_prd[0]));
    want("f_prd1", 8);      check(int'(bus.out_prd[1]));
    want("f_bypass", 2);    check(int'(bus.out_prs1[1]));
    tick();

    // Reset in the second rebuild cycle.
    do_reset();
    bus.flush = 1'b1;
    tick();
    tick();
    want("r_busy_mid", 1);  check(int'(bus.busy));
    rst = 1'b0;
    tick();
    want("r_busy", 0);      check(int'(bus.busy));
    want("r_free_cnt", 32); check(int'(bus.free_cnt));
    rst = 1'b1;
    lane(0, 0, 2, 31); lane(1, 4, 0, 0);
    #1;
    want("r_ready", 3);     check(int'(bus.ready));
    want("r_prs1", 2);      check(int'(bus.out_prs1[0]));
    want("r_prs2", 31);     check(int'(bus.out_prs2[0]));
    want("r_old1", 4);      check(int'(bus.out_old_prd[1]));
    want("r_prd1", 32);     check(int'(bus.out_prd[1]));
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
